// File: rtl/weight_stream_pkg.sv
// Shared types and constants for the weight ROM streaming controller.
package weight_stream_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } stream_state_e;

    localparam int STALL_CNT_WIDTH = 32;

    // Width needed to hold an occupancy of 0..depth inclusive.
    function automatic int fifo_cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/weight_stream_fifo.sv
// First-word-fall-through synchronous FIFO with occupancy count.
// Push while full is accepted only together with a pop in the same cycle.
module weight_stream_fifo
    import weight_stream_pkg::*;
#(
    parameter int DATA_WIDTH = 128,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_WIDTH  = fifo_cnt_width(FIFO_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  empty,
    output logic [CNT_WIDTH-1:0]  count
);

    localparam int PTR_WIDTH = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_WIDTH-1:0]  rd_ptr;
    logic [PTR_WIDTH-1:0]  wr_ptr;
    logic                  full;
    logic                  do_push;
    logic                  do_pop;

    function automatic logic [PTR_WIDTH-1:0] next_ptr(input logic [PTR_WIDTH-1:0] p);
        return (p == PTR_WIDTH'(FIFO_DEPTH - 1)) ? '0 : p + PTR_WIDTH'(1);
    endfunction

    assign empty   = (count == '0);
    assign full    = (count == CNT_WIDTH'(FIFO_DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            if (do_push && !do_pop) begin
                count <= count + CNT_WIDTH'(1);
            end else if (do_pop && !do_push) begin
                count <= count - CNT_WIDTH'(1);
            end
        end
    end

    // Storage is not reset; occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

endmodule

// File: rtl/weight_rom_stream_ctrl.sv
// Streams DEPTH ROM words num_passes times onto a valid/ready port, with credit-based read issue.
// Optional backpressure counter enabled by macro WEIGHT_STREAM_STALL_CNT_EN.
module weight_rom_stream_ctrl
    import weight_stream_pkg::*;
#(
    parameter int DATA_WIDTH  = 128,
    parameter int DEPTH       = 576,
    parameter int ADDR_WIDTH  = $clog2(DEPTH) + 1,
    parameter int ROM_LATENCY = 2,
    parameter int PASS_WIDTH  = 8,
    parameter int FIFO_DEPTH  = ROM_LATENCY + 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [PASS_WIDTH-1:0]      num_passes,
    output logic                       busy,
    output logic                       done,
    output logic [ADDR_WIDTH-1:0]      rom_addr,
    output logic                       rom_ce,
    input  logic [DATA_WIDTH-1:0]      rom_q,
    output logic [DATA_WIDTH-1:0]      data_out,
    output logic                       data_out_valid,
    input  logic                       data_out_ready,
    output logic [STALL_CNT_WIDTH-1:0] stall_cycles
);

    localparam int CNT_WIDTH  = fifo_cnt_width(FIFO_DEPTH);
    localparam int CRED_WIDTH = CNT_WIDTH + 1;

    stream_state_e          state;
    logic [PASS_WIDTH-1:0]  passes_q;
    logic [PASS_WIDTH-1:0]  pass_cnt;
    logic [ROM_LATENCY-1:0] inflight;
    logic [CRED_WIDTH-1:0]  inflight_cnt;
    logic [CNT_WIDTH-1:0]   fifo_count;
    logic                   fifo_empty;
    logic                   issue;
    logic                   pop;
    logic                   last_addr;
    logic                   last_pass;

    always_comb begin
        inflight_cnt = '0;
        for (int i = 0; i < ROM_LATENCY; i++) begin
            inflight_cnt = inflight_cnt + CRED_WIDTH'(inflight[i]);
        end
    end

    // Words already buffered plus words still in the ROM pipe must fit in the FIFO.
    assign issue = (state == RUN) &&
                   ((CRED_WIDTH'(fifo_count) + inflight_cnt) < CRED_WIDTH'(FIFO_DEPTH));

    assign last_addr      = (rom_addr == ADDR_WIDTH'(DEPTH - 1));
    assign last_pass      = (pass_cnt == passes_q - PASS_WIDTH'(1));
    assign data_out_valid = !fifo_empty;
    assign pop            = data_out_valid && data_out_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            passes_q <= '0;
            pass_cnt <= '0;
            rom_addr <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            rom_ce   <= 1'b0;
        end else begin
            rom_ce <= 1'b1;
            done   <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        passes_q <= num_passes;
                        pass_cnt <= '0;
                        rom_addr <= '0;
                        if (num_passes == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= RUN;
                            busy  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (issue) begin
                        if (last_addr) begin
                            rom_addr <= '0;
                            pass_cnt <= pass_cnt + PASS_WIDTH'(1);
                            if (last_pass) begin
                                state <= DRAIN;
                            end
                        end else begin
                            rom_addr <= rom_addr + ADDR_WIDTH'(1);
                        end
                    end
                end
                DRAIN: begin
                    if ((inflight == '0) && (fifo_count == '0)) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Tail of this pipe lines up with the cycle rom_q carries the issued word.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inflight <= '0;
        end else begin
            inflight[0] <= issue;
            for (int i = 1; i < ROM_LATENCY; i++) begin
                inflight[i] <= inflight[i-1];
            end
        end
    end

    weight_stream_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH),
        .CNT_WIDTH  (CNT_WIDTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (inflight[ROM_LATENCY-1]),
        .wr_data (rom_q),
        .pop     (pop),
        .rd_data (data_out),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

`ifdef WEIGHT_STREAM_STALL_CNT_EN
    logic [STALL_CNT_WIDTH-1:0] stall_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_q <= '0;
        end else if ((state == IDLE) && start) begin
            stall_q <= '0;
        end else if (data_out_valid && !data_out_ready && (stall_q != '1)) begin
            stall_q <= stall_q + STALL_CNT_WIDTH'(1);
        end
    end

    assign stall_cycles = stall_q;
`else
    assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_weight_rom_stream_ctrl.sv
// Self-checking bench for weight_rom_stream_ctrl: table of stream runs plus reset/backpressure/re-start sequences.
`timescale 1ns/1ps
module tb_weight_rom_stream_ctrl;

    localparam int DATA_WIDTH  = 16;
    localparam int DEPTH       = 8;
    localparam int ADDR_WIDTH  = $clog2(DEPTH) + 1;
    localparam int ROM_LATENCY = 2;
    localparam int PASS_WIDTH  = 8;
    localparam int FIFO_DEPTH  = ROM_LATENCY + 2;
    localparam int BUDGET      = 200;

    typedef struct {
        int passes;
        int ready_mode;
        int repulse;
        int exp_words;
        int exp_busy;
        int exp_first;
        int exp_done;
    } vec_t;

    logic                  clk;
    logic                  rst;
    logic                  start;
    logic [PASS_WIDTH-1:0] num_passes;
    logic                  busy;
    logic                  done;
    logic [ADDR_WIDTH-1:0] rom_addr;
    logic                  rom_ce;
    logic [DATA_WIDTH-1:0] rom_q;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  data_out_valid;
    logic                  data_out_ready;
    logic [31:0]           stall_cycles;

    logic [DATA_WIDTH-1:0] rom_mem [DEPTH];
    logic [DATA_WIDTH-1:0] rom_stage;

    int                    exp_q[$];
    int                    errors;
    int                    checks;
    int                    stall_seen;
    logic                  held_valid;
    logic [DATA_WIDTH-1:0] held_data;

    weight_rom_stream_ctrl #(
        .DATA_WIDTH  (DATA_WIDTH),
        .DEPTH       (DEPTH),
        .ADDR_WIDTH  (ADDR_WIDTH),
        .ROM_LATENCY (ROM_LATENCY),
        .PASS_WIDTH  (PASS_WIDTH),
        .FIFO_DEPTH  (FIFO_DEPTH)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .num_passes     (num_passes),
        .busy           (busy),
        .done           (done),
        .rom_addr       (rom_addr),
        .rom_ce         (rom_ce),
        .rom_q          (rom_q),
        .data_out       (data_out),
        .data_out_valid (data_out_valid),
        .data_out_ready (data_out_ready),
        .stall_cycles   (stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            rom_mem[i] = DATA_WIDTH'(i);
        end
    end

    // Two registered read stages, matching ROM_LATENCY = 2.
    always @(posedge clk) begin
        if (rom_ce) begin
            rom_stage <= rom_mem[rom_addr[$clog2(DEPTH)-1:0]];
            rom_q     <= rom_stage;
        end
    end

    task automatic check_output(input string name, input longint actual, input longint expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    function automatic logic ready_for(input int mode, input int c);
        if (mode == 0) return 1'b1;
        if (c < 12) return (c % 2) == 0;
        if (c < 22) return 1'b0;
        return 1'b1;
    endfunction

    // Scoreboard: every handshake pops one expected word; stalls must hold the word.
    always @(negedge clk) begin
        if (!rst) begin
            held_valid = 1'b0;
        end else begin
            if (held_valid) begin
                check_output("stall_hold_valid", longint'(data_out_valid), 1);
                check_output("stall_hold_data", longint'(data_out), longint'(held_data));
            end
            if (data_out_valid && data_out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_word: got %0d, expected no word", data_out);
                end else begin
                    check_output("word", longint'(data_out), longint'(exp_q.pop_front()));
                end
            end
            held_valid = data_out_valid && !data_out_ready;
            held_data  = data_out;
            if (data_out_valid && !data_out_ready) stall_seen++;
        end
    end

    // Called just after a rising edge; returns just after a rising edge.
    task automatic apply_stimulus(input int passes, input int ready_mode, input int repulse,
                                  output int n_busy, output int first_valid, output int done_cycle,
                                  output int n_done, output int addr_changes);
        logic [ADDR_WIDTH-1:0] prev_addr;
        for (int p = 0; p < passes; p++) begin
            for (int a = 0; a < DEPTH; a++) exp_q.push_back(a);
        end
        start      = 1'b1;
        num_passes = PASS_WIDTH'(passes);
        @(posedge clk); #1;
        start        = 1'b0;
        num_passes   = PASS_WIDTH'($urandom_range(1, 255));
        stall_seen   = 0;
        n_busy       = 0;
        first_valid  = -1;
        done_cycle   = -1;
        n_done       = 0;
        addr_changes = 0;
        prev_addr    = rom_addr;
        for (int c = 0; c < BUDGET; c++) begin
            data_out_ready = ready_for(ready_mode, c);
            start          = (c == repulse);
            if (c == repulse) num_passes = PASS_WIDTH'(5);
            @(negedge clk);
            if (busy) n_busy++;
            if (data_out_valid && first_valid < 0) first_valid = c;
            if (done) begin
                n_done++;
                done_cycle = c;
            end
            if (rom_addr != prev_addr) addr_changes++;
            prev_addr = rom_addr;
            @(posedge clk); #1;
            if (done_cycle >= 0 && c >= done_cycle + 2) break;
        end
        start          = 1'b0;
        data_out_ready = 1'b1;
    endtask

    task automatic run_vector(input vec_t v);
        int n_busy, first_valid, done_cycle, n_done, addr_changes, exp_stall;
        apply_stimulus(v.passes, v.ready_mode, v.repulse, n_busy, first_valid, done_cycle, n_done, addr_changes);
        check_output("done_pulses", n_done, 1);
        check_output("leftover_words", exp_q.size(), 0);
        check_output("first_valid_cycle", first_valid, v.exp_first);
        check_output("rom_addr_changes", addr_changes, v.exp_words);
        check_output("valid_after_done", longint'(data_out_valid), 0);
        if (v.exp_busy >= 0) check_output("busy_cycles", n_busy, v.exp_busy);
        if (v.exp_done >= 0) check_output("done_cycle", done_cycle, v.exp_done);
`ifdef WEIGHT_STREAM_STALL_CNT_EN
        exp_stall = stall_seen;
`else
        exp_stall = 0;
`endif
        check_output("stall_cycles", longint'(stall_cycles), exp_stall);
        exp_q.delete();
    endtask

    initial begin
        vec_t vecs[4];
        vec_t v;
        vecs[0] = '{passes: 1, ready_mode: 0, repulse: -1, exp_words: 8,  exp_busy: 12, exp_first: 3,  exp_done: 12};
        vecs[1] = '{passes: 3, ready_mode: 0, repulse: -1, exp_words: 24, exp_busy: 28, exp_first: 3,  exp_done: 28};
        vecs[2] = '{passes: 0, ready_mode: 0, repulse: -1, exp_words: 0,  exp_busy: 0,  exp_first: -1, exp_done: 0};
        vecs[3] = '{passes: 2, ready_mode: 0, repulse: -1, exp_words: 16, exp_busy: 20, exp_first: 3,  exp_done: 20};

        errors         = 0;
        checks         = 0;
        stall_seen     = 0;
        held_valid     = 1'b0;
        rst            = 1'b0;
        start          = 1'b0;
        num_passes     = '0;
        data_out_ready = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_output("reset_busy", longint'(busy), 0);
        check_output("reset_done", longint'(done), 0);
        check_output("reset_valid", longint'(data_out_valid), 0);
        check_output("reset_rom_addr", longint'(rom_addr), 0);
        check_output("reset_stall", longint'(stall_cycles), 0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check_output("rom_ce_after_reset", longint'(rom_ce), 1);

        for (int i = 0; i < 4; i++) begin
            $display("[TB] table vector %0d: num_passes=%0d", i, vecs[i].passes);
            run_vector(vecs[i]);
        end

        $display("[TB] backpressure run");
        v = '{passes: 2, ready_mode: 1, repulse: -1, exp_words: 16, exp_busy: -1, exp_first: 3, exp_done: -1};
        run_vector(v);

        $display("[TB] start re-pulsed during RUN");
        v = '{passes: 2, ready_mode: 0, repulse: 5, exp_words: 16, exp_busy: 20, exp_first: 3, exp_done: 20};
        run_vector(v);

        // Reset in pass 1 after the consumer stops long enough to fill the buffer.
        $display("[TB] reset mid-stream");
        for (int k = 0; k < 2 * DEPTH; k++) exp_q.push_back(k % DEPTH);
        start      = 1'b1;
        num_passes = PASS_WIDTH'(2);
        @(posedge clk); #1;
        start = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        data_out_ready = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        check_output("pre_reset_valid", longint'(data_out_valid), 1);
        rst = 1'b0;
        #1;
        check_output("mid_reset_valid", longint'(data_out_valid), 0);
        check_output("mid_reset_busy", longint'(busy), 0);
        check_output("mid_reset_stall", longint'(stall_cycles), 0);
        exp_q.delete();
        repeat (2) begin
            @(negedge clk);
            check_output("mid_reset_done", longint'(done), 0);
        end
        @(posedge clk); #1;
        rst            = 1'b1;
        data_out_ready = 1'b1;
        @(posedge clk); #1;
        run_vector(vecs[0]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog");
    end

endmodule
